oh_rseq: RTL and testbench

//  Reset sequencer downstream of the reset synchronizer. Its input is the synchronized

---
 rtl/oh_rseq_if.sv | 24 ++
 rtl/oh_rseq.sv | 113 +++++++++++
 tb/tb_oh_rseq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/oh_rseq_if.sv
// Handshake bundle between the reset sequencer and its software-reset controller.
// The master drives the request; the slave (the sequencer) drives the reset outputs.
interface oh_rseq_if #(
    parameter int unsigned N = 4
) ();
    logic         sw_req;
    logic [N-1:0] nrst_out;
    logic         busy;
    logic         done;

    modport master (
        output sw_req,
        input  nrst_out,
        input  busy,
        input  done
    );

    modport slave (
        input  sw_req,
        output nrst_out,
        output busy,
        output done
    );
endinterface

// File: rtl/oh_rseq.sv
// Reset sequencer: holds N domains in reset for HOLD cycles, then releases them one at a
// time GAP cycles apart, lowest index first; a software request in DONE re-runs the sequence.
module oh_rseq #(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 16,
    parameter int unsigned GAP  = 4,
    parameter int unsigned CW   = 8
) (
    input logic     clk,
    input logic     rst,
    oh_rseq_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] HoldLast = CW'(HOLD - 1);
    localparam logic [CW-1:0] GapLast  = CW'(GAP - 1);
    localparam logic [CW-1:0] CntMax   = '1;
    localparam logic [IW-1:0] IdxLast  = IW'(N - 1);
    localparam logic [N-1:0]  FirstBit = N'(1);

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  nrst_q, nrst_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_inc;
    logic [N-1:0]  next_bit;

    // Saturating increment so the counter can never wrap back into range.
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    assign next_bit = FirstBit << (32'(idx_q) + 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
        done_d  = done_q;
        unique case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nrst_d  = FirstBit;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelease: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        nrst_d = nrst_q | next_bit;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                if (bus.sw_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nrst_d  = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
                idx_d   = '0;
                nrst_d  = '0;
                done_d  = 1'b0;
            end
        endcase
        busy_d = ~done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.nrst_out = nrst_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_oh_rseq.sv
// Directed bench for oh_rseq: default-parameter instance plus an N=1/HOLD=1/GAP=1 instance.
module tb_oh_rseq;
    logic clk;
    logic rst;
    logic rst1;
    int   tests;
    int   fails;

    oh_rseq_if #(.N(4)) bus ();
    oh_rseq_if #(.N(1)) bus1 ();

    oh_rseq #(.N(4), .HOLD(16), .GAP(4), .CW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    oh_rseq #(.N(1), .HOLD(1), .GAP(1), .CW(8)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {nrst_out, done, busy} at edge e of a default-parameter sequence (edge 0 = start).
    function automatic logic [5:0] exp_main(int e);
        logic [3:0] n;
        logic       d;
        for (int k = 0; k < 4; k++) n[k] = (e >= 16 + 4 * k);
        d = (e >= 32);
        return {n, d, ~d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== 6'b0000_01) begin
                fails++;
                $display("FAIL reset cyc%0d: got %b want 000001", i,
                         {bus.nrst_out, bus.done, bus.busy});
            end
        end
    endtask

    task automatic test_power_on();
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                fails++;
                $display("FAIL power_on edge%0d: got %b want %b", e,
                         {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
            end
        end
    endtask

    task automatic test_soft_reset();
        bus.sw_req = 1'b1;
        step();
        bus.sw_req = 1'b0;
        tests++;
        if ({bus.nrst_out, bus.done, bus.busy} !== 6'b0000_01) begin
            fails++;
            $display("FAIL soft_accept: got %b want 000001", {bus.nrst_out, bus.done, bus.busy});
        end
        for (int e = 1; e <= 32; e++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                fails++;
                $display("FAIL soft edge%0d: got %b want %b", e,
                         {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== 6'b1111_10) begin
                fails++;
                $display("FAIL soft_stay%0d: got %b want 111110", i,
                         {bus.nrst_out, bus.done, bus.busy});
            end
        end
    endtask

    task automatic test_busy_ignore();
        bus.sw_req = 1'b1;
        step();
        bus.sw_req = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            bus.sw_req = (e == 10);
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                fails++;
                $display("FAIL busy_ignore edge%0d: got %b want %b", e,
                         {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
            end
        end
        bus.sw_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== 6'b1111_10) begin
                fails++;
                $display("FAIL not_queued%0d: got %b want 111110", i,
                         {bus.nrst_out, bus.done, bus.busy});
            end
        end
    endtask

    task automatic test_rst_mid();
        bus.sw_req = 1'b1;
        step();
        bus.sw_req = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                fails++;
                $display("FAIL pre_rst edge%0d: got %b want %b", e,
                         {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
            end
        end
        rst = 1'b1;
        step();
        tests++;
        if ({bus.nrst_out, bus.done, bus.busy} !== 6'b0000_01) begin
            fails++;
            $display("FAIL rst_mid: got %b want 000001", {bus.nrst_out, bus.done, bus.busy});
        end
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            tests++;
            if ({bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                fails++;
                $display("FAIL post_rst edge%0d: got %b want %b", e,
                         {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
            end
        end
    endtask

    task automatic test_sw_held();
        int dcnt;
        bus.sw_req = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            dcnt = 0;
            for (int e = 1; e <= 33; e++) begin
                step();
                if (bus.done === 1'b1) dcnt++;
                tests++;
                if ((bus.nrst_out & (bus.nrst_out + 4'd1)) !== 4'd0) begin
                    fails++;
                    $display("FAIL order p%0d edge%0d: got %b", p, e, bus.nrst_out);
                end
                tests++;
                if (e <= 32 && {bus.nrst_out, bus.done, bus.busy} !== exp_main(e)) begin
                    fails++;
                    $display("FAIL held p%0d edge%0d: got %b want %b", p, e,
                             {bus.nrst_out, bus.done, bus.busy}, exp_main(e));
                end else if (e == 33 && {bus.nrst_out, bus.done, bus.busy} !== 6'b0000_01) begin
                    fails++;
                    $display("FAIL held_restart p%0d: got %b want 000001", p,
                             {bus.nrst_out, bus.done, bus.busy});
                end
            end
            tests++;
            if (dcnt != 1) begin
                fails++;
                $display("FAIL done_once p%0d: got %0d cycles want 1", p, dcnt);
            end
        end
        bus.sw_req = 1'b0;
    endtask

    task automatic test_degenerate();
        rst1 = 1'b1;
        step();
        tests++;
        if ({bus1.nrst_out, bus1.done, bus1.busy} !== 3'b001) begin
            fails++;
            $display("FAIL deg_reset: got %b want 001", {bus1.nrst_out, bus1.done, bus1.busy});
        end
        rst1 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step();
            tests++;
            if ({bus1.nrst_out, bus1.done, bus1.busy} !== 3'b101) begin
                fails++;
                $display("FAIL deg_e1 run%0d: got %b want 101", r,
                         {bus1.nrst_out, bus1.done, bus1.busy});
            end
            step();
            tests++;
            if ({bus1.nrst_out, bus1.done, bus1.busy} !== 3'b110) begin
                fails++;
                $display("FAIL deg_e2 run%0d: got %b want 110", r,
                         {bus1.nrst_out, bus1.done, bus1.busy});
            end
            if (r == 0) begin
                bus1.sw_req = 1'b1;
                step();
                bus1.sw_req = 1'b0;
                tests++;
                if ({bus1.nrst_out, bus1.done, bus1.busy} !== 3'b001) begin
                    fails++;
                    $display("FAIL deg_accept: got %b want 001",
                             {bus1.nrst_out, bus1.done, bus1.busy});
                end
            end
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        rst1         = 1'b1;
        bus.sw_req   = 1'b0;
        bus1.sw_req  = 1'b0;
        test_reset();
        test_power_on();
        test_soft_reset();
        test_busy_ignore();
        test_rst_mid();
        test_sw_held();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
